rf_bypass: RTL and testbench
============================

RF_BYPASS -- requirements
Module: rf_bypass

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the data width of every register and port; it matches the ALU operand width.
REQ-002 The module SHALL have parameter NREG, default 8, giving the register count; it SHALL be a power of two, with select width log2(NREG) (3 at default).
REQ-003 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port read1RegSel, input, 3 bits: register index for read port 1, which feeds ALU operand A.
REQ-006 Port read2RegSel, input, 3 bits: register index for read port 2, which feeds ALU operand B.
REQ-007 Port writeRegSel, input, 3 bits: register index for the write port.
REQ-008 Port writeData, input, WIDTH bits: write data, normally the ALU result from the writeback stage.
REQ-009 Port writeEn, input, 1 bit: write enable.
REQ-010 Port read1Data, output, WIDTH bits: port 1 read data.
REQ-011 Port read2Data, output, WIDTH bits: port 2 read data.
REQ-012 Port wrCount, output, 16 bits: count of committed writes, for performance and verification.

Function
REQ-013 Storage SHALL be NREG registers of WIDTH bits, all flip-flops, with no latches and no memory inference.
REQ-014 When writeEn=1 on a rising clk edge, register[writeRegSel] SHALL take writeData; no other register changes.
REQ-015 When writeEn=0, no register SHALL change.
REQ-016 Read ports SHALL be combinational (zero-cycle latency), with each output determined only by current inputs and current register state.
REQ-017 Bypass: if writeEn=1 and writeRegSel equals readNRegSel, readNData SHALL equal writeData in the same cycle; otherwise it SHALL equal register[readNRegSel].
REQ-018 Bypass SHALL be evaluated independently per port, so both ports may bypass in the same cycle.
REQ-019 Register 0 SHALL be an ordinary writable register; there is no hard-wired zero.
REQ-020 Reads of the same index on both ports SHALL return identical data.
REQ-021 wrCount SHALL increment by 1 on each rising edge with writeEn=1.
REQ-022 wrCount SHALL wrap from 16'hFFFF to 16'h0000 without saturating.
REQ-023 Every valid select value is in range at NREG=8, so no out-of-range handling is required.

Reset
REQ-024 While rst_n=0, all registers and wrCount SHALL be 0 immediately, with no clock required.
REQ-025 While rst_n=0, read1Data and read2Data SHALL be 0 unless bypass is active; bypass SHALL remain purely combinational during reset.
REQ-026 While rst_n=0, writes SHALL be blocked: writeEn=1 during reset SHALL NOT change any register or wrCount.
REQ-027 Deassertion of rst_n SHALL take effect so that the first rising edge after deassertion performs a normal write if writeEn=1.
REQ-028 Reset asserted mid-write (between edges) SHALL clear state at once, and the pending write SHALL be lost.

Verification
REQ-029 Scenario 1: Reset with rst_n=0 and no clock, then read all 8 indices via both ports with writeEn=0 -> all reads 16'h0000 and wrCount=0.
REQ-030 Scenario 2: Write r3=16'hBEEF, then next cycle read1RegSel=3, read2RegSel=4, writeEn=0 -> read1Data=16'hBEEF, read2Data=16'h0000, wrCount=1.
REQ-031 Scenario 3 (bypass): writeEn=1, writeRegSel=5, writeData=16'h1234, read1RegSel=5, read2RegSel=5, with r5 previously 16'h0001 -> both reads 16'h1234 before the edge; after the edge with writeEn=0, both reads 16'h1234.
REQ-032 Scenario 4 (no write): writeEn=0, writeRegSel=2, writeData=16'hFFFF, read1RegSel=2 -> read1Data holds its old value, r2 is unchanged, and wrCount is unchanged.
REQ-033 Scenario 5 (reset mid-operation): after writing r7=16'hA5A5, pulse rst_n low between edges -> read of r7 returns 16'h0000 immediately and wrCount=0.
REQ-034 Scenario 6 (wrap): perform 65536 consecutive writes -> wrCount returns to 16'h0000, and the final written value is readable.

Source files
------------

// File: rtl/rf_bypass.sv
// Register file with NREG flip-flop registers, one write port and two
// combinational read ports. A same-cycle write to a read index is forwarded
// to that port, and wrCount counts committed writes.
module rf_bypass #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  localparam int SEL_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] read1RegSel,
  input  logic [SEL_W-1:0] read2RegSel,
  input  logic [SEL_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic [15:0]      wrCount
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [15:0]      wr_count_q;
  logic [15:0]      wr_count_d;
  logic             bypass1;
  logic             bypass2;

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (writeEn) begin
      regs_d[writeRegSel] = writeData;
      wr_count_d          = wr_count_q + 16'd1;
    end
  end

  // Reset holds every flop at zero, which also blocks writes while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Forwarding is purely combinational, so it stays live even during reset.
  assign bypass1   = writeEn && (writeRegSel == read1RegSel);
  assign bypass2   = writeEn && (writeRegSel == read2RegSel);
  assign read1Data = bypass1 ? writeData : regs_q[read1RegSel];
  assign read2Data = bypass2 ? writeData : regs_q[read2RegSel];
  assign wrCount   = wr_count_q;

endmodule

// File: tb/tb_rf_bypass.sv
// Bench for rf_bypass: fixed vector table, hand sequences for reset and
// wrap corners, and random traffic checked against an array model.
module tb_rf_bypass;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n;
  logic [2:0]  r1_sel, r2_sel, w_sel;
  logic [15:0] w_data;
  logic        w_en;
  logic [15:0] r1_data, r2_data, wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_regs [8];
  logic [15:0] model_cnt;

  typedef struct {
    logic        we;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [11];

  rf_bypass #(.WIDTH(16), .NREG(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read1RegSel (r1_sel),
    .read2RegSel (r2_sel),
    .writeRegSel (w_sel),
    .writeData   (w_data),
    .writeEn     (w_en),
    .read1Data   (r1_data),
    .read2Data   (r2_data),
    .wrCount     (wr_count)
  );

  // clock / reset
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] ws, input logic [15:0] wd,
                       input logic [2:0] r1, input logic [2:0] r2);
    w_en   = we;
    w_sel  = ws;
    w_data = wd;
    r1_sel = r1;
    r2_sel = r2;
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] rs);
    if (w_en && (w_sel == rs)) return w_data;
    return model_regs[rs];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    model_cnt = 16'h0000;
  endtask

  task automatic model_commit();
    if (w_en && rst_n) begin
      model_regs[w_sel] = w_data;
      model_cnt         = model_cnt + 16'd1;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd4, 16'hBEEF, 16'h0000, 16'd0};
    vecs[1]  = '{1'b0, 3'd3, 16'h0000, 3'd3, 3'd4, 16'hBEEF, 16'h0000, 16'd1};
    vecs[2]  = '{1'b1, 3'd5, 16'h0001, 3'd5, 3'd0, 16'h0001, 16'h0000, 16'd1};
    vecs[3]  = '{1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 16'h1234, 16'h1234, 16'd2};
    vecs[4]  = '{1'b0, 3'd5, 16'h0000, 3'd5, 3'd5, 16'h1234, 16'h1234, 16'd3};
    vecs[5]  = '{1'b0, 3'd2, 16'hFFFF, 3'd2, 3'd3, 16'h0000, 16'hBEEF, 16'd3};
    vecs[6]  = '{1'b0, 3'd2, 16'hFFFF, 3'd2, 3'd2, 16'h0000, 16'h0000, 16'd3};
    vecs[7]  = '{1'b1, 3'd0, 16'hCAFE, 3'd0, 3'd1, 16'hCAFE, 16'h0000, 16'd3};
    vecs[8]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'hCAFE, 16'hCAFE, 16'd4};
    vecs[9]  = '{1'b1, 3'd7, 16'hA5A5, 3'd7, 3'd3, 16'hA5A5, 16'hBEEF, 16'd4};
    vecs[10] = '{1'b0, 3'd7, 16'h0000, 3'd7, 3'd5, 16'hA5A5, 16'h1234, 16'd5};

    // Reset with no clock running: every index reads zero on both ports.
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    #3;
    for (int i = 0; i < 8; i++) begin
      r1_sel = i[2:0];
      r2_sel = 3'(7 - i);
      #1;
      chk("reset_read1", r1_data, 16'h0000);
      chk("reset_read2", r2_data, 16'h0000);
    end
    chk("reset_wrcount", wr_count, 16'h0000);

    clk_en = 1'b1;
    #2;
    rst_n = 1'b1;
    model_reset();

    // Table-driven vectors, checked before each rising edge.
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      drive(vecs[v].we, vecs[v].ws, vecs[v].wd, vecs[v].r1, vecs[v].r2);
      #1;
      chk($sformatf("vec%0d_read1", v), r1_data, vecs[v].e1);
      chk($sformatf("vec%0d_read2", v), r2_data, vecs[v].e2);
      chk($sformatf("vec%0d_wrcount", v), wr_count, vecs[v].ecnt);
      model_commit();
    end

    // Reset mid-write: state clears at once, bypass still forwards.
    @(negedge clk);
    drive(1'b1, 3'd7, 16'h1111, 3'd7, 3'd6);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_bypass", r1_data, 16'h1111);
    chk("midrst_read2", r2_data, 16'h0000);
    chk("midrst_wrcount", wr_count, 16'h0000);
    w_en = 1'b0;
    #1;
    chk("midrst_r7", r1_data, 16'h0000);
    model_reset();

    // Write attempted across a rising edge while held in reset is blocked.
    @(negedge clk);
    drive(1'b1, 3'd6, 16'h7777, 3'd0, 3'd6);
    @(posedge clk);
    #1;
    w_en = 1'b0;
    #1;
    chk("rst_blocked_r6", r2_data, 16'h0000);
    chk("rst_blocked_cnt", wr_count, 16'h0000);

    // First edge after release performs a normal write.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd1, 16'h4242, 3'd1, 3'd2);
    model_commit();
    @(posedge clk);
    #1;
    w_en = 1'b0;
    #1;
    chk("post_rst_r1", r1_data, 16'h4242);
    chk("post_rst_r2", r2_data, 16'h0000);
    chk("post_rst_cnt", wr_count, 16'h0001);

    // Random traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      #1;
      chk("rand_read1", r1_data, model_read(r1_sel));
      chk("rand_read2", r2_data, model_read(r2_sel));
      chk("rand_wrcount", wr_count, model_cnt);
      model_commit();
    end

    // Wrap: 65536 writes from a clean count bring wrCount back to zero.
    @(negedge clk);
    w_en = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      drive(1'b1, i[2:0], i[15:0], 3'd0, 3'd1);
      if (i == 65535) begin
        #1;
        chk("wrap_pre_ffff", wr_count, 16'hFFFF);
      end
    end
    @(posedge clk);
    #1;
    drive(1'b0, 3'd0, 16'h0000, 3'd7, 3'd0);
    #1;
    chk("wrap_cnt_zero", wr_count, 16'h0000);
    chk("wrap_last_r7", r1_data, 16'hFFFF);
    chk("wrap_r0", r2_data, 16'hFFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
